// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants and phase encodings for the 800x600@72 Hz raster
// generator (50 MHz pixel clock).
//  - VGA_H_* / VGA_V_* : default porch/sync/active lengths and totals
//  - X_W / Y_W         : widths of the x/y coordinate outputs
//  - h_phase_t / v_phase_t : one-hot phase encodings {ACT, FP, SY, BP}
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int VGA_H_ACTIVE = 800;
   localparam int VGA_H_FRONT  = 56;
   localparam int VGA_H_SYNC   = 120;
   localparam int VGA_H_BACK   = 64;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_ACTIVE = 600;
   localparam int VGA_V_FRONT  = 37;
   localparam int VGA_V_SYNC   = 6;
   localparam int VGA_V_BACK   = 23;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic [3:0] {
      H_ACT = 4'b0001,
      H_FP  = 4'b0010,
      H_SY  = 4'b0100,
      H_BP  = 4'b1000
   } h_phase_t;

   typedef enum logic [3:0] {
      V_ACT = 4'b0001,
      V_FP  = 4'b0010,
      V_SY  = 4'b0100,
      V_BP  = 4'b1000
   } v_phase_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// DLY-stage shift register that lines the sync outputs up with the render
// stage's registered colour output. DLY=0 is a plain wire.
// Ports:
//  clk  in        pixel clock
//  rst  in        asynchronous active-low reset; every stage loads RST_LVL
//  i_d  in  [W]   undelayed bits
//  o_q  out [W]   bits delayed by DLY clocks
// ---------------------------------------------------------------------------
module sync_delay #(
   parameter int   W       = 2,
   parameter int   DLY     = 1,
   parameter logic RST_LVL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   generate
      if (DLY == 0) begin : g_pass
         assign o_q = i_d;
      end else begin : g_shift
         logic [DLY-1:0][W-1:0] r_stage;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_stage <= {DLY{ {W{RST_LVL}} }};
            end else begin
               r_stage[0] <= i_d;
               for (int i = 1; i < DLY; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_q = r_stage[DLY-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing source: pixel coordinates, active-video flag, delayed
// HSYNC/VSYNC and a start-of-vertical-blank frame tick.
// Optional feature macro: VGA_FRAME_CNT_EN
//  defined   -> frame_cnt counts frame ticks (wraps at 65535)
//  undefined -> frame_cnt is tied to zero, no counter is built
// Ports:
//  clk         in        pixel clock
//  rst         in        asynchronous active-low reset
//  x           out [11]  column, 0..H_TOTAL-1
//  y           out [10]  line, 0..V_TOTAL-1
//  o_active    out       visible-area flag, coherent with x/y
//  hsync       out       horizontal sync, delayed SYNC_DLY clocks
//  vsync       out       vertical sync, delayed SYNC_DLY clocks
//  frame_tick  out       one clock at x==0, y==V_ACTIVE
//  frame_cnt   out [16]  frame counter
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FRONT  = VGA_H_FRONT,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BACK   = VGA_H_BACK,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FRONT  = VGA_V_FRONT,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BACK   = VGA_V_BACK,
   parameter logic SYNC_POL = 1'b1,
   parameter int   SYNC_DLY = 1
) (
   input  logic           clk,
   input  logic           rst,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           o_active,
   output logic           hsync,
   output logic           vsync,
   output logic           frame_tick,
   output logic [15:0]    frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Last coordinate of each phase; the FSMs leave a phase on these values.
   localparam logic [X_W-1:0] X_ACT_END = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0] X_FP_END  = X_W'(H_ACTIVE + H_FRONT - 1);
   localparam logic [X_W-1:0] X_SY_END  = X_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [X_W-1:0] X_LAST    = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_ACT_END = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_FP_END  = Y_W'(V_ACTIVE + V_FRONT - 1);
   localparam logic [Y_W-1:0] Y_SY_END  = Y_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [Y_W-1:0] Y_LAST    = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_TICK    = Y_W'(V_ACTIVE);

   generate
      if (H_TOTAL > 2047) begin : g_h_too_big
         $error("vga_timing_gen: H_TOTAL must be <= 2047");
      end
      if (V_TOTAL > 1023) begin : g_v_too_big
         $error("vga_timing_gen: V_TOTAL must be <= 1023");
      end
      if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_dly_range
         $error("vga_timing_gen: SYNC_DLY must be 0..4");
      end
   endgenerate

   logic           r_run;
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic           r_active;
   logic           r_frame_tick;
   h_phase_t       r_h_phase;
   v_phase_t       r_v_phase;

   logic [X_W-1:0] w_x_next;
   logic [Y_W-1:0] w_y_next;
   h_phase_t       w_h_next;
   v_phase_t       w_v_next;
   logic           w_x_wrap;
   logic           w_y_wrap;
   logic           w_active_next;
   logic           w_tick_next;
   logic [1:0]     w_sync_raw;
   logic [1:0]     w_sync_dly;

   // y only wraps when it is on its last line at the moment x wraps.
   assign w_x_wrap = r_run && (r_x == X_LAST);
   assign w_y_wrap = w_x_wrap && (r_y == Y_LAST);

   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      if (r_run) begin
         w_x_next = w_x_wrap ? '0 : r_x + X_W'(1);
         if (w_y_wrap) begin
            w_y_next = '0;
         end else if (w_x_wrap) begin
            w_y_next = r_y + Y_W'(1);
         end
      end
   end

   // Horizontal phase: steps on the last column of each region.
   always_comb begin
      w_h_next = r_h_phase;
      if (r_run) begin
         case (r_h_phase)
            H_ACT:   if (r_x == X_ACT_END) w_h_next = H_FP;
            H_FP:    if (r_x == X_FP_END)  w_h_next = H_SY;
            H_SY:    if (r_x == X_SY_END)  w_h_next = H_BP;
            H_BP:    if (r_x == X_LAST)    w_h_next = H_ACT;
            default: w_h_next = H_ACT;
         endcase
      end
   end

   // Vertical phase: same shape, but only evaluated on the x wrap.
   always_comb begin
      w_v_next = r_v_phase;
      if (w_x_wrap) begin
         case (r_v_phase)
            V_ACT:   if (r_y == Y_ACT_END) w_v_next = V_FP;
            V_FP:    if (r_y == Y_FP_END)  w_v_next = V_SY;
            V_SY:    if (r_y == Y_SY_END)  w_v_next = V_BP;
            V_BP:    if (r_y == Y_LAST)    w_v_next = V_ACT;
            default: w_v_next = V_ACT;
         endcase
      end
   end

   // Gating with the pre-edge run flag keeps o_active low for the first
   // clock after reset release, while x/y sit at 0,0 waiting to advance.
   assign w_active_next = r_run && (w_h_next == H_ACT) && (w_v_next == V_ACT);
   assign w_tick_next   = r_run && (w_x_next == '0) && (w_y_next == Y_TICK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run        <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_active     <= 1'b0;
         r_frame_tick <= 1'b0;
         r_h_phase    <= H_ACT;
         r_v_phase    <= V_ACT;
      end else begin
         r_run        <= 1'b1;
         r_x          <= w_x_next;
         r_y          <= w_y_next;
         r_active     <= w_active_next;
         r_frame_tick <= w_tick_next;
         r_h_phase    <= w_h_next;
         r_v_phase    <= w_v_next;
      end
   end

   assign w_sync_raw[1] = (r_h_phase == H_SY) ? SYNC_POL : ~SYNC_POL;
   assign w_sync_raw[0] = (r_v_phase == V_SY) ? SYNC_POL : ~SYNC_POL;

   sync_delay #(
      .W       (2),
      .DLY     (SYNC_DLY),
      .RST_LVL (~SYNC_POL)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .i_d (w_sync_raw),
      .o_q (w_sync_dly)
   );

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_cnt <= '0;
      end else if (r_frame_tick) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`else
   assign frame_cnt = '0;
`endif

   assign x          = r_x;
   assign y          = r_y;
   assign o_active   = r_active;
   assign frame_tick = r_frame_tick;
   assign hsync      = w_sync_dly[1];
   assign vsync      = w_sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen with a shrunken raster (28 x 17) so that several
// complete frames fit in a short run. A reference model pushes the expected
// outputs for every clock into a queue; a checker pops and compares them on
// the falling edge. Directed checks cover asynchronous reset, sync pulse
// width, frame-tick period and the frame counter.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 3, HS = 5, HB = 4;
   localparam int VA = 10, VF = 2, VS = 3, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME_CLKS = HT * VT;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        act;
      logic        hs;
      logic        vs;
      logic        tick;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [10:0] x;
   logic [9:0]  y;
   logic        o_active;
   logic        hsync;
   logic        vsync;
   logic        frame_tick;
   logic [15:0] frame_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .SYNC_POL (1'b1),
      .SYNC_DLY (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .y          (y),
      .o_active   (o_active),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_tick (frame_tick),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // n counts clock edges since reset release; the raster advances from the
   // second edge on, so pixel index p = n-1.
   int          m_n = 0;
   int          m_prev_x = 0;
   int          m_prev_y = 0;
   logic        m_prev_tick = 1'b0;
   logic [15:0] m_cnt = '0;

   always @(posedge clk) begin
      exp_t e;
      int   p, ex, ey;
      if (!rst) begin
         m_n = 0;
         m_cnt = '0;
         ex = 0;
         ey = 0;
         e = '0;
      end else begin
`ifdef VGA_FRAME_CNT_EN
         if (m_prev_tick) m_cnt = m_cnt + 16'd1;
`endif
         m_n++;
         p  = m_n - 1;
         ex = p % HT;
         ey = (p / HT) % VT;
         e.x    = 11'(ex);
         e.y    = 10'(ey);
         e.act  = (m_n >= 2) && (ex < HA) && (ey < VA);
         e.tick = (m_n >= 2) && (ex == 0) && (ey == VA);
         // One clock of sync delay: sync reflects the previous coordinate.
         e.hs   = (m_prev_x >= HA + HF) && (m_prev_x < HA + HF + HS);
         e.vs   = (m_prev_y >= VA + VF) && (m_prev_y < VA + VF + VS);
         e.cnt  = m_cnt;
      end
      m_prev_x    = ex;
      m_prev_y    = ey;
      m_prev_tick = e.tick;
      sb_q.push_back(e);
   end

   // ---------------- scoreboard checker ----------------
   int cyc = 0;
   int hs_len = 0;
   int last_tick_cyc = -1;
   int ticks_seen = 0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_val("x",          32'(x),          32'(e.x));
         check_val("y",          32'(y),          32'(e.y));
         check_val("o_active",   32'(o_active),   32'(e.act));
         check_val("hsync",      32'(hsync),      32'(e.hs));
         check_val("vsync",      32'(vsync),      32'(e.vs));
         check_val("frame_tick", 32'(frame_tick), 32'(e.tick));
         check_val("frame_cnt",  32'(frame_cnt),  32'(e.cnt));
         $display("cyc=%0d x=%0d y=%0d act=%0b hs=%0b vs=%0b tick=%0b cnt=%0d",
                  cyc, x, y, o_active, hsync, vsync, frame_tick, frame_cnt);
      end
      // Independent pulse-width and frame-period measurements.
      if (hsync === 1'b1) begin
         hs_len++;
      end else if (hs_len != 0) begin
         check_val("hsync_width", 32'(hs_len), 32'(HS));
         hs_len = 0;
      end
      if (!rst) begin
         last_tick_cyc = -1;
      end else if (frame_tick === 1'b1) begin
         ticks_seen++;
         if (last_tick_cyc >= 0) check_val("tick_period", 32'(cyc - last_tick_cyc), 32'(FRAME_CLKS));
         last_tick_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int   exp_cnt;
      logic found;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;

      // Three frames worth of ticks (first tick after ~y=10 lines).
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (ticks_seen >= 3) begin
            found = 1'b1;
            break;
         end
      end
      check_val("wait_3_ticks", 32'(found), 32'd1);
      repeat (2) @(negedge clk);
`ifdef VGA_FRAME_CNT_EN
      exp_cnt = 3;
`else
      exp_cnt = 0;
`endif
      check_val("frame_cnt_after_3", 32'(frame_cnt), 32'(exp_cnt));

      // Mid-frame asynchronous reset at the scaled-down x=HA/2, y=VA/2.
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (x == 11'(HA / 2) && y == 10'(VA / 2)) begin
            found = 1'b1;
            break;
         end
      end
      check_val("wait_mid_frame", 32'(found), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_val("rst_x",          32'(x),          32'd0);
      check_val("rst_y",          32'(y),          32'd0);
      check_val("rst_o_active",   32'(o_active),   32'd0);
      check_val("rst_frame_tick", 32'(frame_tick), 32'd0);
      check_val("rst_hsync",      32'(hsync),      32'd0);
      check_val("rst_vsync",      32'(vsync),      32'd0);
      check_val("rst_frame_cnt",  32'(frame_cnt),  32'd0);
      @(negedge clk);
      #1 rst = 1'b1;

      // Run past the next frame tick and a full frame after the restart.
      repeat (FRAME_CLKS + 40) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #(200 * FRAME_CLKS);
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
